// File: rtl/multi_axis_profile_gen_pkg.sv
// Shared types and default widths for the multi-axis profile generator.
package multi_axis_profile_gen_pkg;

  localparam int unsigned X_W_DEF  = 64;
  localparam int unsigned V_W_DEF  = 32;
  localparam int unsigned FRAC_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StAbort
  } state_e;

endpackage

// File: rtl/profile_axis.sv
// One motion axis: velocity/accel/jerk update, saturation, abort ramp,
// trapezoidal position integration and step/dir generation.
module profile_axis
  import multi_axis_profile_gen_pkg::*;
#(
  parameter int unsigned X_W  = X_W_DEF,
  parameter int unsigned V_W  = V_W_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           acc_step,
  input  logic           run_tick,
  input  logic           abort_tick,
  input  logic           load_v,
  input  logic [V_W-1:0] v_in,
  input  logic           load_aj,
  input  logic [V_W-1:0] a_in,
  input  logic [V_W-1:0] j_in,
  input  logic           clear_aj,
  input  logic           x_load,
  input  logic [X_W-1:0] x_val,
  input  logic [5:0]     step_bit,
  input  logic [V_W-1:0] abort_a,
  output logic [X_W-1:0] x,
  output logic [V_W-1:0] v,
  output logic           step,
  output logic           dir,
  output logic           stopped,
  output logic           ramp_zero
);

  // Wide enough for (v << FRAC) + a without overflow.
  localparam int unsigned WW = V_W + FRAC + 2;
  localparam logic signed [WW-1:0]  VMAX_W = {{(WW-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] VMAX   = {1'b0, {(V_W-1){1'b1}}};

  logic signed [X_W-1:0] x_q, x_d, x_inc;
  logic signed [V_W-1:0] v_q, v_d, vp_q, vp_d, a_q, a_d, j_q, j_d;
  logic signed [V_W-1:0] v_run, v_ramp;
  logic signed [WW-1:0]  acc_w, q_w;
  logic signed [V_W:0]   sum, half;
  logic [V_W-1:0]        abs_v;
  logic                  step_d, dir_d;

  // Saturating velocity update, abort ramp and trapezoidal position increment.
  always_comb begin
    acc_w = (WW'(v_q) <<< FRAC) + WW'(a_q);
    q_w   = acc_w >>> FRAC;
    if (q_w > VMAX_W) begin
      v_run = VMAX;
    end else if (q_w < -VMAX_W) begin
      v_run = -VMAX;
    end else begin
      v_run = q_w[V_W-1:0];
    end

    abs_v = v_q[V_W-1] ? -v_q : v_q;
    if (abs_v <= abort_a) begin
      v_ramp = '0;
    end else if (v_q[V_W-1]) begin
      v_ramp = v_q + abort_a;
    end else begin
      v_ramp = v_q - abort_a;
    end

    sum   = {v_q[V_W-1], v_q} + {vp_q[V_W-1], vp_q};
    half  = sum >>> 1;
    x_inc = X_W'(half);
  end

  // Next-state for the axis registers.
  always_comb begin
    v_d  = v_q;
    vp_d = vp_q;
    a_d  = a_q;
    j_d  = j_q;
    if (acc_step) vp_d = v_q;
    if (run_tick) begin
      v_d = v_run;
      a_d = a_q + j_q;
    end
    if (abort_tick) v_d = v_ramp;
    if (load_aj) begin
      a_d = a_in;
      j_d = j_in;
    end
    if (clear_aj) begin
      a_d = '0;
      j_d = '0;
    end
    if (load_v) v_d = v_in;
    if (x_load) vp_d = v_q;

    x_d    = x_load ? x_val : x_q + x_inc;
    step_d = !x_load && (x_d[step_bit] != x_q[step_bit]);
    dir_d  = step_d ? (!sum[V_W] && (sum != '0)) : dir;
  end

  // Axis state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      v_q  <= '0;
      vp_q <= '0;
      a_q  <= '0;
      j_q  <= '0;
      step <= 1'b0;
      dir  <= 1'b0;
    end else begin
      x_q  <= x_d;
      v_q  <= v_d;
      vp_q <= vp_d;
      a_q  <= a_d;
      j_q  <= j_d;
      step <= step_d;
      dir  <= dir_d;
    end
  end

  assign x         = x_q;
  assign v         = v_q;
  assign stopped   = (sum == '0);
  assign ramp_zero = (v_ramp == '0);

endmodule

// File: rtl/multi_axis_profile_gen.sv
// Multi-axis motion profile generator: segment FSM, one-entry shadow buffer
// and tick counter driving N_AXES profile_axis instances.
module multi_axis_profile_gen
  import multi_axis_profile_gen_pkg::*;
#(
  parameter int unsigned N_AXES = 3,
  parameter int unsigned X_W    = X_W_DEF,
  parameter int unsigned V_W    = V_W_DEF,
  parameter int unsigned FRAC   = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acc_step,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  input  logic [N_AXES*V_W-1:0] seg_v,
  input  logic [N_AXES*V_W-1:0] seg_a,
  input  logic [N_AXES*V_W-1:0] seg_j,
  input  logic [N_AXES-1:0]     seg_set_v,
  input  logic [31:0]           seg_ticks,
  input  logic                  x_load,
  input  logic [N_AXES*X_W-1:0] x_val,
  input  logic [5:0]            step_bit,
  input  logic                  abort,
  input  logic [V_W-1:0]        abort_a,
  output logic [N_AXES*X_W-1:0] x,
  output logic [N_AXES*V_W-1:0] v,
  output logic [N_AXES-1:0]     step,
  output logic [N_AXES-1:0]     dir,
  output logic                  busy,
  output logic                  seg_done,
  output logic [N_AXES-1:0]     stopped
);

  state_e state_q, state_d;
  logic   sh_full_q, sh_full_d;
  logic [N_AXES*V_W-1:0] sh_v_q, sh_a_q, sh_j_q;
  logic [N_AXES-1:0]     sh_set_v_q;
  logic [31:0]           sh_ticks_q, ticks_left_q, ticks_left_d;
  logic                  seg_done_d;
  logic                  accept, promote, clear_aj, load_aj, run_tick, abort_tick;
  logic [N_AXES-1:0]     ramp_zero;

  assign seg_ready  = !sh_full_q && (state_q != StAbort);
  assign busy       = (state_q != StIdle) || sh_full_q;
  assign run_tick   = (state_q == StRun) && acc_step && !abort;
  assign abort_tick = (state_q == StAbort) && acc_step;
  assign load_aj    = promote && (sh_ticks_q != 32'd0);

  // Segment sequencing: promotion, tick countdown, abort.
  always_comb begin
    state_d      = state_q;
    sh_full_d    = sh_full_q;
    ticks_left_d = ticks_left_q;
    seg_done_d   = 1'b0;
    accept       = 1'b0;
    promote      = 1'b0;
    clear_aj     = 1'b0;
    if (abort) begin
      // Abort beats any handshake or promotion in the same cycle.
      state_d   = StAbort;
      sh_full_d = 1'b0;
      clear_aj  = 1'b1;
    end else begin
      accept = seg_valid && seg_ready;
      unique case (state_q)
        StIdle: promote = sh_full_q;
        StRun: begin
          if (acc_step) begin
            ticks_left_d = ticks_left_q - 32'd1;
            if (ticks_left_q == 32'd1) begin
              seg_done_d = 1'b1;
              if (sh_full_q) begin
                promote = 1'b1;
              end else begin
                clear_aj = 1'b1;
                state_d  = StIdle;
              end
            end
          end
        end
        StAbort: if (acc_step && (&ramp_zero)) state_d = StIdle;
        default: state_d = StIdle;
      endcase
      if (promote) begin
        sh_full_d = 1'b0;
        if (sh_ticks_q == 32'd0) begin
          // Zero-length segment only applies its velocity presets.
          seg_done_d = 1'b1;
          clear_aj   = 1'b1;
          state_d    = StIdle;
        end else begin
          ticks_left_d = sh_ticks_q;
          state_d      = StRun;
        end
      end
      if (accept) sh_full_d = 1'b1;
    end
  end

  // FSM, counter and shadow buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      sh_full_q    <= 1'b0;
      ticks_left_q <= '0;
      seg_done     <= 1'b0;
      sh_v_q       <= '0;
      sh_a_q       <= '0;
      sh_j_q       <= '0;
      sh_set_v_q   <= '0;
      sh_ticks_q   <= '0;
    end else begin
      state_q      <= state_d;
      sh_full_q    <= sh_full_d;
      ticks_left_q <= ticks_left_d;
      seg_done     <= seg_done_d;
      if (accept) begin
        sh_v_q     <= seg_v;
        sh_a_q     <= seg_a;
        sh_j_q     <= seg_j;
        sh_set_v_q <= seg_set_v;
        sh_ticks_q <= seg_ticks;
      end
    end
  end

  for (genvar k = 0; k < N_AXES; k++) begin : g_axis
    profile_axis #(
      .X_W  (X_W),
      .V_W  (V_W),
      .FRAC (FRAC)
    ) u_axis (
      .clk        (clk),
      .reset      (reset),
      .acc_step   (acc_step),
      .run_tick   (run_tick),
      .abort_tick (abort_tick),
      .load_v     (promote && sh_set_v_q[k]),
      .v_in       (sh_v_q[k*V_W +: V_W]),
      .load_aj    (load_aj),
      .a_in       (sh_a_q[k*V_W +: V_W]),
      .j_in       (sh_j_q[k*V_W +: V_W]),
      .clear_aj   (clear_aj),
      .x_load     (x_load),
      .x_val      (x_val[k*X_W +: X_W]),
      .step_bit   (step_bit),
      .abort_a    (abort_a),
      .x          (x[k*X_W +: X_W]),
      .v          (v[k*V_W +: V_W]),
      .step       (step[k]),
      .dir        (dir[k]),
      .stopped    (stopped[k]),
      .ramp_zero  (ramp_zero[k])
    );
  end

endmodule
